oled_i2c_master: RTL and testbench
==================================

# oled_i2c_master

Byte-level I2C master that sequences START, 8 data bits, ACK and STOP/repeated-START on the OLED bus. It replaces free-running SCL/SDA waveform generation with a state machine driven by a quarter-bit tick. Upstream command/frame logic feeds it bytes over a valid/ready handshake. Outputs are logical bus levels; the pad wrapper maps 1 to high-Z (open-drain) and feeds the pin back as `sda_i`.

## Interface
- `QUARTER`, 175: clk cycles per quarter bit period; a bit is 4×QUARTER, so 700 cycles. Legal range 2..2^20−1.
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `tx_valid`  in  1  byte available
- `tx_ready`  out  1  block accepts a byte this cycle
- `tx_data`  in  8  byte, sent MSB first
- `tx_start`  in  1  with the byte: emit (repeated) START first
- `tx_stop`  in  1  with the byte: emit STOP after its ACK
- `bus_release`  in  1  in HOLD: emit STOP without data
- `sda_i`  in  1  SDA pin readback, sampled for ACK
- `scl`  out  1  SCL level
- `sda`  out  1  SDA level
- `busy`  out  1  state ≠ IDLE
- `ack_err`  out  1  sticky NACK flag

## Operation
- States: IDLE, START, DATA, ACK, HOLD, STOP. Each state lasts whole quarters q0..q3; DATA lasts 8 bits.
- Accept means `tx_valid && tx_ready`. `tx_ready` = (state==IDLE) or (state==HOLD && !bus_release). It is combinational. On accept, `tx_data`, `tx_start` and `tx_stop` are registered.
- IDLE: scl=1, sda=1. On accept, go to START. `tx_start` is ignored here because START is always emitted. `ack_err` clears on this accept.
- START: q0 sda=1 and scl holds its previous value. q1 sda=1, scl=1. q2 sda=0, scl=1. q3 sda=0, scl=0. Then go to DATA.
- DATA, per bit: sda=bit is set on q0 entry, scl=0 in q0–q1 and scl=1 in q2–q3. After bit 0 (LSB), go to ACK.
- ACK: sda=1 (released), same SCL pattern. `sda_i` is sampled on the last clk of q2.
  - Sample 1 (NACK): set `ack_err`, go to STOP. Any held `tx_stop` is irrelevant.
  - Sample 0 and `tx_stop`: go to STOP.
  - Otherwise: go to HOLD.
- HOLD: scl=0, sda=0, bus owned.
  - Accept with `tx_start`=1: go to START (repeated start; SCL stays low during START q0).
  - Accept with `tx_start`=0: go to DATA directly, first bit driven on the next q0.
  - `bus_release`: go to STOP. It has priority over `tx_valid`.
- STOP: q0 sda=0, scl=0. q1 sda=0, scl=1. q2–q3 sda=1, scl=1. Then go to IDLE.
- `ack_err` is set only by NACK and cleared only by accept-from-IDLE or reset.

## Timing
- Reset values (asynchronous): state=IDLE, scl=1, sda=1, busy=0, ack_err=0, tick counter=0. `tx_ready`=1 during and after reset.
- Reset mid-transfer forces scl=sda=1 immediately, so the bus may see a truncated frame. This is accepted behaviour with no recovery sequence.
- The quarter counter restarts at 0 on every accept. In HOLD the counter is stopped.
- From accept in IDLE, START q0 begins on the next clk.
- Frame lengths:
  - START+byte+ACK = 40 quarters.
  - Adding STOP = 44 quarters, i.e. 7700 clk at the default. `busy` falls 44×QUARTER clk after accept.
  - A HOLD→DATA byte takes 36 quarters to reach the next HOLD.
- The `scl`/`sda` outputs are registered and change only on quarter boundaries.
- The counter is 20 bits wide and counts 0..QUARTER−1 before wrapping. The bit index is 3 bits and counts down 7..0.

## Structure
- Package `oled_i2c_pkg`:
  - state enum `i2c_state_t`
  - 2-bit quarter-phase type `i2c_phase_t`
  - constant `I2C_QUARTER_DEFAULT` = 175
- Sub-module `i2c_quarter_tick` (QUARTER parameter, `clear` and `enable` inputs, `tick` output on the last count). It is the only counter shared with the main FSM; the FSM owns the phase and bit counters.

## Test plan
Use QUARTER=4 unless noted.
- **Reset:** hold rst_n=0 with arbitrary inputs → scl=1, sda=1, busy=0, ack_err=0, tx_ready=1. Release → outputs stay put until the first accept.
- **Single write with STOP:** tx_data=0xA5, start=1, stop=1, sda_i tied 0 → START; SDA bits 1,0,1,0,0,1,0,1 stable while SCL is high; ACK; STOP. busy high for exactly 176 clk; ack_err=0.
- **NACK:** sda_i=1 during ACK, stop=0 → ack_err=1, then STOP, then IDLE. The next accepted byte clears ack_err at accept.
- **Hold and repeated start:** byte 0x78 with stop=0 → HOLD with scl=0, sda=0, tx_ready=1. Then 0x3C with start=1 → SDA rises while SCL is low, then a START pattern. Then 0xAF with stop=1 → STOP.
- **Priority:** in HOLD, tx_valid=1 and bus_release=1 in the same cycle → tx_ready=0, no accept, STOP. The byte is accepted later from IDLE.
- **Mid-frame reset:** assert rst_n=0 in DATA bit 3 → scl=1, sda=1 in the same cycle (asynchronous). After release, a fresh 0x00 frame completes normally.

Source files
------------

// File: rtl/oled_i2c_pkg.sv
// rtl/oled_i2c_pkg.sv - shared types and constants for the OLED I2C master
package oled_i2c_pkg;

    localparam int I2C_QUARTER_DEFAULT = 175;
    localparam int I2C_CNT_W           = 20;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_ACK   = 3'd3,
        ST_HOLD  = 3'd4,
        ST_STOP  = 3'd5
    } i2c_state_t;

    typedef logic [1:0] i2c_phase_t;

endpackage

// File: rtl/oled_i2c_master_if.sv
// rtl/oled_i2c_master_if.sv - byte handshake and bus-level signals of the OLED I2C master
interface oled_i2c_master_if;

    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_stop;
    logic       bus_release;
    logic       sda_i;
    logic       scl;
    logic       sda;
    logic       busy;
    logic       ack_err;

    modport master (
        input  tx_valid, tx_data, tx_start, tx_stop, bus_release, sda_i,
        output tx_ready, scl, sda, busy, ack_err
    );

    modport slave (
        output tx_valid, tx_data, tx_start, tx_stop, bus_release, sda_i,
        input  tx_ready, scl, sda, busy, ack_err
    );

endinterface

// File: rtl/oled_i2c_master_quarter_tick.sv
// rtl/oled_i2c_master_quarter_tick.sv - quarter-bit period counter with single-cycle tick
module i2c_quarter_tick
    import oled_i2c_pkg::*;
#(
    parameter int QUARTER = I2C_QUARTER_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam logic [I2C_CNT_W-1:0] LAST = I2C_CNT_W'(QUARTER - 1);

    logic [I2C_CNT_W-1:0] cnt;

    assign tick = enable && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/oled_i2c_master.sv
// rtl/oled_i2c_master.sv - byte-level I2C master: START, 8 data bits, ACK, STOP/repeated START
module oled_i2c_master
    import oled_i2c_pkg::*;
#(
    parameter int QUARTER = I2C_QUARTER_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    oled_i2c_master_if.master bus
);

    localparam logic [2:0] S_IDLE  = ST_IDLE;
    localparam logic [2:0] S_START = ST_START;
    localparam logic [2:0] S_DATA  = ST_DATA;
    localparam logic [2:0] S_ACK   = ST_ACK;
    localparam logic [2:0] S_HOLD  = ST_HOLD;
    localparam logic [2:0] S_STOP  = ST_STOP;

    logic [2:0] state;
    i2c_phase_t phase;
    logic [2:0] bit_idx;
    logic [7:0] data_q;
    logic       stop_q;
    logic       nack_q;
    logic       scl_q;
    logic       sda_q;
    logic       ack_err_q;
    logic       accept;
    logic       tick;
    logic       cnt_en;

    assign bus.tx_ready = (state == S_IDLE) || (state == S_HOLD && !bus.bus_release);
    assign accept       = bus.tx_valid && bus.tx_ready;
    // Counter only runs while a quarter-timed state is active; HOLD parks the bus.
    assign cnt_en       = (state != S_IDLE) && (state != S_HOLD);

    assign bus.scl      = scl_q;
    assign bus.sda      = sda_q;
    assign bus.busy     = (state != S_IDLE);
    assign bus.ack_err  = ack_err_q;

    i2c_quarter_tick #(.QUARTER(QUARTER)) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (accept),
        .enable (cnt_en),
        .tick   (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            phase     <= '0;
            bit_idx   <= 3'd7;
            data_q    <= '0;
            stop_q    <= 1'b0;
            nack_q    <= 1'b0;
            scl_q     <= 1'b1;
            sda_q     <= 1'b1;
            ack_err_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        data_q    <= bus.tx_data;
                        stop_q    <= bus.tx_stop;
                        ack_err_q <= 1'b0;
                        phase     <= '0;
                        state     <= S_START;
                    end
                end
                S_HOLD: begin
                    if (bus.bus_release) begin
                        phase <= '0;
                        state <= S_STOP;
                    end else if (accept) begin
                        data_q <= bus.tx_data;
                        stop_q <= bus.tx_stop;
                        phase  <= '0;
                        if (bus.tx_start) begin
                            // Repeated START: release SDA while SCL is still low.
                            sda_q <= 1'b1;
                            state <= S_START;
                        end else begin
                            bit_idx <= 3'd7;
                            sda_q   <= bus.tx_data[7];
                            state   <= S_DATA;
                        end
                    end
                end
                default: begin
                    if (tick) begin
                        // Each branch sets the bus levels for the quarter that is about to begin.
                        phase <= phase + 2'd1;
                        case (state)
                            S_START: begin
                                case (phase)
                                    2'd0: scl_q <= 1'b1;
                                    2'd1: sda_q <= 1'b0;
                                    2'd2: scl_q <= 1'b0;
                                    2'd3: begin
                                        bit_idx <= 3'd7;
                                        sda_q   <= data_q[7];
                                        state   <= S_DATA;
                                    end
                                endcase
                            end
                            S_DATA: begin
                                case (phase)
                                    2'd0: ;
                                    2'd1: scl_q <= 1'b1;
                                    2'd2: ;
                                    2'd3: begin
                                        scl_q <= 1'b0;
                                        if (bit_idx == 3'd0) begin
                                            sda_q <= 1'b1;
                                            state <= S_ACK;
                                        end else begin
                                            bit_idx <= bit_idx - 3'd1;
                                            sda_q   <= data_q[bit_idx - 3'd1];
                                        end
                                    end
                                endcase
                            end
                            S_ACK: begin
                                case (phase)
                                    2'd0: ;
                                    2'd1: scl_q <= 1'b1;
                                    2'd2: begin
                                        nack_q <= bus.sda_i;
                                        if (bus.sda_i) ack_err_q <= 1'b1;
                                    end
                                    2'd3: begin
                                        scl_q <= 1'b0;
                                        sda_q <= 1'b0;
                                        state <= (nack_q || stop_q) ? S_STOP : S_HOLD;
                                    end
                                endcase
                            end
                            S_STOP: begin
                                case (phase)
                                    2'd0: scl_q <= 1'b1;
                                    2'd1: sda_q <= 1'b1;
                                    2'd2: ;
                                    2'd3: state <= S_IDLE;
                                endcase
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_oled_i2c_master.sv
// tb/tb_oled_i2c_master.sv - self-checking bench for oled_i2c_master
module tb_oled_i2c_master;

    localparam int Q        = 4;
    localparam int EV_START = 1000;
    localparam int EV_STOP  = 1001;

    typedef struct {
        logic [7:0] data;
        logic       start;
        logic       stop;
        logic       ack_ok;
        int         exp_clk;
        logic       exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic slave_ack = 1'b1;
    logic slave_pull = 1'b0;

    int errors = 0;
    int checks = 0;

    int mon_ev[$];
    int exp_ev[$];
    logic owned = 1'b0;
    logic m_err = 1'b0;

    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    int         bitcnt = 0;
    logic [7:0] shreg = '0;

    oled_i2c_master_if bus ();

    oled_i2c_master #(.QUARTER(Q)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Open-drain bus: the slave model can only pull the line low.
    assign bus.sda_i = bus.sda & ~slave_pull;

    // Bus decoder and ACK-driving slave, sampled away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            bitcnt     = 0;
            slave_pull = 1'b0;
            prev_scl   = 1'b1;
            prev_sda   = 1'b1;
        end else begin
            if (prev_scl && bus.scl && prev_sda && !bus.sda_i) begin
                mon_ev.push_back(EV_START);
                bitcnt = 0;
                shreg  = '0;
            end else if (prev_scl && bus.scl && !prev_sda && bus.sda_i) begin
                mon_ev.push_back(EV_STOP);
                bitcnt = 0;
            end else if (!prev_scl && bus.scl) begin
                if (bitcnt == 9) bitcnt = 0;
                if (bitcnt < 8) begin
                    shreg  = {shreg[6:0], bus.sda_i};
                    bitcnt = bitcnt + 1;
                end else begin
                    mon_ev.push_back(int'({bus.sda_i, shreg}));
                    bitcnt = 9;
                end
            end else if (prev_scl && !bus.scl) begin
                slave_pull = (bitcnt == 8) && slave_ack;
            end
            prev_scl = bus.scl;
            prev_sda = bus.sda_i;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_events(input string name);
        int bad;
        bad = -1;
        if (mon_ev.size() != exp_ev.size()) bad = 0;
        else foreach (exp_ev[i]) if (bad < 0 && mon_ev[i] != exp_ev[i]) bad = i;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s: bus events got %0d items (first %0h) expected %0d items (first %0h) diff at %0d",
                     name, mon_ev.size(), (mon_ev.size() > bad) ? mon_ev[bad] : -1,
                     exp_ev.size(), (exp_ev.size() > bad) ? exp_ev[bad] : -1, bad);
        end
        mon_ev.delete();
        exp_ev.delete();
    endtask

    // Reference model: bus-level event list and duration derived from the frame rules.
    function automatic int model_byte(input logic [7:0] d, input logic st, input logic sp, input logic ack_ok);
        int q;
        q = 36;
        if (!owned) m_err = 1'b0;
        if (!owned || st) begin
            exp_ev.push_back(EV_START);
            q += 4;
        end
        exp_ev.push_back(int'({~ack_ok, d}));
        if (!ack_ok) m_err = 1'b1;
        if (!ack_ok || sp) begin
            exp_ev.push_back(EV_STOP);
            owned = 1'b0;
            q += 4;
        end else begin
            owned = 1'b1;
        end
        return q * Q;
    endfunction

    function automatic void model_release();
        if (owned) exp_ev.push_back(EV_STOP);
        owned = 1'b0;
    endfunction

    task automatic send_byte(input logic [7:0] d, input logic st, input logic sp, input logic ack_ok);
        int n;
        n = 0;
        slave_ack = ack_ok;
        @(negedge clk);
        while (!bus.tx_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!bus.tx_ready) begin
            checks++;
            errors++;
            $display("FAIL send_wait: tx_ready got 0 expected 1 after %0d cycles", n);
        end
        bus.tx_valid = 1'b1;
        bus.tx_data  = d;
        bus.tx_start = st;
        bus.tx_stop  = sp;
        @(posedge clk);
        #1;
        bus.tx_valid = 1'b0;
    endtask

    task automatic wait_ready(input string name, output int n);
        n = 0;
        while (1) begin
            @(negedge clk);
            if (bus.tx_ready) break;
            n++;
            if (n > 2000) begin
                checks++;
                errors++;
                $display("FAIL %s: timeout got busy>%0d cycles expected ready", name, n);
                break;
            end
        end
    endtask

    initial begin
        vec_t vecs[5];
        int   n;
        int   exp_n;
        logic [7:0] d;
        logic st, sp, ak;

        vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b1, 176, 1'b0};
        vecs[1] = '{8'h00, 1'b1, 1'b1, 1'b1, 176, 1'b0};
        vecs[2] = '{8'hFF, 1'b0, 1'b1, 1'b1, 176, 1'b0};
        vecs[3] = '{8'h5A, 1'b1, 1'b0, 1'b0, 176, 1'b1};
        vecs[4] = '{8'h81, 1'b0, 1'b1, 1'b0, 176, 1'b1};

        // Reset with arbitrary inputs.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #2;
            bus.tx_valid    = 1'($urandom);
            bus.tx_data     = 8'($urandom);
            bus.tx_start    = 1'($urandom);
            bus.tx_stop     = 1'($urandom);
            bus.bus_release = 1'($urandom);
        end
        @(negedge clk);
        check("rst_scl", bus.scl, 1);
        check("rst_sda", bus.sda, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_ack_err", bus.ack_err, 0);
        check("rst_tx_ready", bus.tx_ready, 1);
        bus.tx_valid    = 1'b0;
        bus.bus_release = 1'b0;
        rst_n           = 1'b1;
        repeat (6) @(negedge clk);
        check("idle_scl", bus.scl, 1);
        check("idle_sda", bus.sda, 1);
        check("idle_busy", bus.busy, 0);
        check("idle_tx_ready", bus.tx_ready, 1);

        // Table: single frames from IDLE that end back in IDLE.
        for (int i = 0; i < 5; i++) begin
            send_byte(vecs[i].data, vecs[i].start, vecs[i].stop, vecs[i].ack_ok);
            check("accept_clears_ack_err", bus.ack_err, 0);
            void'(model_byte(vecs[i].data, vecs[i].start, vecs[i].stop, vecs[i].ack_ok));
            wait_ready("vec_wait", n);
            check("vec_busy_clk", n, vecs[i].exp_clk);
            check("vec_idle", bus.busy, 0);
            check("vec_ack_err", bus.ack_err, vecs[i].exp_err);
            check_events("vec_events");
        end

        // Hold, repeated start, HOLD->DATA, then STOP.
        send_byte(8'h78, 1'b1, 1'b0, 1'b1);
        exp_n = model_byte(8'h78, 1'b1, 1'b0, 1'b1);
        wait_ready("hold_wait", n);
        check("hold_clk", n, 160);
        check("hold_model_clk", n, exp_n);
        check("hold_scl", bus.scl, 0);
        check("hold_sda", bus.sda, 0);
        check("hold_busy", bus.busy, 1);
        send_byte(8'h3C, 1'b1, 1'b0, 1'b1);
        void'(model_byte(8'h3C, 1'b1, 1'b0, 1'b1));
        @(negedge clk);
        check("rstart_sda_up_scl_low", {bus.scl, bus.sda}, 2'b01);
        wait_ready("rstart_wait", n);
        check("rstart_clk", n + 1, 160);
        send_byte(8'h11, 1'b0, 1'b0, 1'b1);
        void'(model_byte(8'h11, 1'b0, 1'b0, 1'b1));
        wait_ready("hold_data_wait", n);
        check("hold_data_clk", n, 144);
        send_byte(8'hAF, 1'b0, 1'b1, 1'b1);
        void'(model_byte(8'hAF, 1'b0, 1'b1, 1'b1));
        wait_ready("hold_stop_wait", n);
        check("hold_stop_clk", n, 160);
        check("hold_stop_idle", bus.busy, 0);
        check_events("hold_events");

        // bus_release beats tx_valid in HOLD; the byte goes out later from IDLE.
        send_byte(8'h5E, 1'b1, 1'b0, 1'b1);
        void'(model_byte(8'h5E, 1'b1, 1'b0, 1'b1));
        wait_ready("prio_hold_wait", n);
        bus.tx_valid    = 1'b1;
        bus.tx_data     = 8'hC3;
        bus.tx_start    = 1'b0;
        bus.tx_stop     = 1'b1;
        bus.bus_release = 1'b1;
        #1;
        check("prio_tx_ready", bus.tx_ready, 0);
        @(posedge clk);
        #1;
        bus.bus_release = 1'b0;
        model_release();
        wait_ready("prio_stop_wait", n);
        check("prio_stop_clk", n, 16);
        check("prio_idle", bus.busy, 0);
        @(posedge clk);
        #1;
        bus.tx_valid = 1'b0;
        void'(model_byte(8'hC3, 1'b0, 1'b1, 1'b1));
        wait_ready("prio_byte_wait", n);
        check("prio_byte_clk", n, 176);
        check_events("prio_events");

        // Asynchronous reset in DATA bit 3, then a clean frame.
        send_byte(8'h00, 1'b1, 1'b1, 1'b1);
        repeat (84) @(posedge clk);
        #2;
        check("mid_pre_scl", bus.scl, 0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_scl", bus.scl, 1);
        check("mid_rst_sda", bus.sda, 1);
        check("mid_rst_busy", bus.busy, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        mon_ev.delete();
        exp_ev.delete();
        owned = 1'b0;
        m_err = 1'b0;
        send_byte(8'h00, 1'b1, 1'b1, 1'b1);
        void'(model_byte(8'h00, 1'b1, 1'b1, 1'b1));
        wait_ready("mid_wait", n);
        check("mid_frame_clk", n, 176);
        check_events("mid_events");

        // Randomized sessions against the reference model.
        for (int s = 0; s < 10; s++) begin
            for (int b = 0; b < 4; b++) begin
                d  = 8'($urandom);
                st = 1'($urandom);
                sp = ($urandom_range(0, 3) == 0);
                ak = ($urandom_range(0, 4) != 0);
                send_byte(d, st, sp, ak);
                exp_n = model_byte(d, st, sp, ak);
                wait_ready("rnd_wait", n);
                check("rnd_clk", n, exp_n);
                if (!owned) break;
                if ($urandom_range(0, 3) == 0 || b == 3) begin
                    bus.bus_release = 1'b1;
                    @(posedge clk);
                    #1;
                    bus.bus_release = 1'b0;
                    model_release();
                    wait_ready("rnd_release_wait", n);
                    check("rnd_release_clk", n, 16);
                    break;
                end
            end
            check("rnd_idle", bus.busy, 0);
            check("rnd_ack_err", bus.ack_err, m_err);
            check_events("rnd_events");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
